// File: rtl/cache_miss_ctrl.sv
// Miss handler: writes back a dirty victim, fetches or merges the missed byte, returns a one-cycle fill.
// Optional MISS_STATS_EN adds saturating miss_cnt / wb_cnt outputs.
module cache_miss_ctrl #(
  parameter int unsigned RAM_LAT = 2,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RAM_AW  = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              miss_req,
  input  logic              miss_rw,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic [DATA_W-1:0] miss_wdata,
  input  logic [1:0]        miss_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [DATA_W-1:0] victim_data,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_enab,
  output logic              ram_rw,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              fill_valid,
  output logic [1:0]        fill_way,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_dirty,
  output logic              busy,
`ifdef MISS_STATS_EN
  output logic              overrun,
  output logic [7:0]        miss_cnt,
  output logic [7:0]        wb_cnt
`else
  output logic              overrun
`endif
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [1:0]          way_q, way_d;
  logic [RAM_AW-1:0]   vaddr_q, vaddr_d;
  logic [DATA_W-1:0]   vdata_q, vdata_d;
  logic                overrun_d;
  logic                last_c;

  logic                ram_enab_d, ram_rw_d, fill_valid_d, fill_dirty_d, busy_d;
  logic [RAM_AW-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d;

  // Victim tag bits above the RAM index never reach the RAM.
  logic unused_vaddr_hi;
  assign unused_vaddr_hi = ^victim_addr[ADDR_W-1:RAM_AW];

  assign last_c = (cnt_q == CNT_W'(RAM_LAT - 1));

  // Next state, latches and registered-output values decoded from the next state.
  always_comb begin
    state_d      = state_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    data_d       = data_q;
    way_d        = way_q;
    vaddr_d      = vaddr_q;
    vdata_d      = vdata_q;
    overrun_d    = overrun;
    ram_enab_d   = 1'b0;
    ram_rw_d     = 1'b0;
    ram_addr_d   = '0;
    ram_wdata_d  = '0;
    fill_valid_d = 1'b0;
    fill_dirty_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_req) begin
          rw_d    = miss_rw;
          addr_d  = miss_addr;
          data_d  = miss_wdata;
          way_d   = miss_way;
          vaddr_d = victim_addr[RAM_AW-1:0];
          vdata_d = victim_data;
          if (victim_valid && victim_dirty) state_d = WB;
          else if (!miss_rw)                state_d = RD;
          else                              state_d = FILL;
        end
      end
      WB: if (last_c) state_d = rw_q ? FILL : RD;
      RD: begin
        if (last_c) begin
          data_d  = ram_rdata;
          state_d = FILL;
        end
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (miss_req && (state_q != IDLE)) overrun_d = 1'b1;

    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + CNT_W'(1);

    busy_d = (state_d != IDLE);
    case (state_d)
      WB: begin
        ram_enab_d  = 1'b1;
        ram_rw_d    = 1'b1;
        ram_addr_d  = vaddr_d;
        ram_wdata_d = vdata_d;
      end
      RD: begin
        ram_enab_d = 1'b1;
        ram_addr_d = addr_d[RAM_AW-1:0];
      end
      FILL: begin
        fill_valid_d = 1'b1;
        fill_dirty_d = rw_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      way_q      <= '0;
      vaddr_q    <= '0;
      vdata_q    <= '0;
      ram_enab   <= 1'b0;
      ram_rw     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      fill_valid <= 1'b0;
      fill_way   <= '0;
      fill_addr  <= '0;
      fill_data  <= '0;
      fill_dirty <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      way_q      <= way_d;
      vaddr_q    <= vaddr_d;
      vdata_q    <= vdata_d;
      ram_enab   <= ram_enab_d;
      ram_rw     <= ram_rw_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      fill_valid <= fill_valid_d;
      fill_way   <= fill_valid_d ? way_d  : 2'b00;
      fill_addr  <= fill_valid_d ? addr_d : '0;
      fill_data  <= fill_valid_d ? data_d : '0;
      fill_dirty <= fill_dirty_d;
      busy       <= busy_d;
      overrun    <= overrun_d;
    end
  end

`ifdef MISS_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (clr) begin
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if ((state_q == IDLE) && miss_req && (miss_cnt != 8'hFF))
        miss_cnt <= miss_cnt + 8'(1);
      if ((state_d == WB) && (state_q != WB) && (wb_cnt != 8'hFF))
        wb_cnt <= wb_cnt + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: u0 runs with RAM_LAT=2, u1 with RAM_LAT=1 for back-to-back misses.
module tb_cache_miss_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr, miss_req0, miss_req1, miss_rw;
  logic [7:0] miss_addr, miss_wdata, victim_addr, victim_data;
  logic [1:0] miss_way;
  logic       victim_valid, victim_dirty;

  logic       ram_enab0, ram_rw0, fill_valid0, fill_dirty0, busy0, overrun0;
  logic [2:0] ram_addr0;
  logic [7:0] ram_wdata0, fill_addr0, fill_data0, rdata0;
  logic [1:0] fill_way0;
  logic       ram_enab1, ram_rw1, fill_valid1, fill_dirty1, busy1, overrun1;
  logic [2:0] ram_addr1;
  logic [7:0] ram_wdata1, fill_addr1, fill_data1, rdata1;
  logic [1:0] fill_way1;
`ifdef MISS_STATS_EN
  logic [7:0] miss_cnt0, wb_cnt0, miss_cnt1, wb_cnt1;
`endif

  logic [7:0] mem [8];
  assign rdata0 = mem[ram_addr0];
  assign rdata1 = mem[ram_addr1];

  cache_miss_ctrl #(.RAM_LAT(2)) u0 (
    .clk(clk), .clr(clr), .miss_req(miss_req0), .miss_rw(miss_rw), .miss_addr(miss_addr),
    .miss_wdata(miss_wdata), .miss_way(miss_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .ram_rdata(rdata0), .ram_enab(ram_enab0), .ram_rw(ram_rw0), .ram_addr(ram_addr0),
    .ram_wdata(ram_wdata0), .fill_valid(fill_valid0), .fill_way(fill_way0),
    .fill_addr(fill_addr0), .fill_data(fill_data0), .fill_dirty(fill_dirty0),
    .busy(busy0),
`ifdef MISS_STATS_EN
    .miss_cnt(miss_cnt0), .wb_cnt(wb_cnt0),
`endif
    .overrun(overrun0));

  cache_miss_ctrl #(.RAM_LAT(1)) u1 (
    .clk(clk), .clr(clr), .miss_req(miss_req1), .miss_rw(miss_rw), .miss_addr(miss_addr),
    .miss_wdata(miss_wdata), .miss_way(miss_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_data(victim_data),
    .ram_rdata(rdata1), .ram_enab(ram_enab1), .ram_rw(ram_rw1), .ram_addr(ram_addr1),
    .ram_wdata(ram_wdata1), .fill_valid(fill_valid1), .fill_way(fill_way1),
    .fill_addr(fill_addr1), .fill_data(fill_data1), .fill_dirty(fill_dirty1),
    .busy(busy1),
`ifdef MISS_STATS_EN
    .miss_cnt(miss_cnt1), .wb_cnt(wb_cnt1),
`endif
    .overrun(overrun1));

  typedef struct {
    int         cyc;
    logic       rw;
    logic [2:0] addr;
    logic [7:0] wdata;
  } ram_t;

  typedef struct {
    int         cyc;
    logic [1:0] way;
    logic [7:0] addr;
    logic [7:0] data;
    logic       dirty;
  } fill_t;

  ram_t  exp_ram0[$], exp_ram1[$];
  fill_t exp_fill0[$], exp_fill1[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ram(input int idx, input int c, input logic rw, input logic [2:0] a,
                          input logic [7:0] wd);
    ram_t e;
    e.cyc = c; e.rw = rw; e.addr = a; e.wdata = wd;
    if (idx == 0) exp_ram0.push_back(e);
    else          exp_ram1.push_back(e);
  endtask

  task automatic push_fill(input int idx, input int c, input logic [1:0] w, input logic [7:0] a,
                           input logic [7:0] d, input logic dirty);
    fill_t e;
    e.cyc = c; e.way = w; e.addr = a; e.data = d; e.dirty = dirty;
    if (idx == 0) exp_fill0.push_back(e);
    else          exp_fill1.push_back(e);
  endtask

  task automatic mon(input int idx, input logic en, input logic rw, input logic [2:0] a,
                     input logic [7:0] wd, input logic fv, input logic [1:0] w,
                     input logic [7:0] fa, input logic [7:0] fd, input logic fdirty);
    ram_t  r;
    fill_t f;
    int    n;
    if (en) begin
      n = (idx == 0) ? exp_ram0.size() : exp_ram1.size();
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL ram%0d_unexpected at cycle %0d: actual rw=%0d addr=%0h required no access",
                 idx, cyc, rw, a);
      end else begin
        if (idx == 0) r = exp_ram0.pop_front();
        else          r = exp_ram1.pop_front();
        chk($sformatf("ram%0d_cycle", idx), cyc, r.cyc);
        chk($sformatf("ram%0d_rw", idx), 32'(rw), 32'(r.rw));
        chk($sformatf("ram%0d_addr", idx), 32'(a), 32'(r.addr));
        if (r.rw) chk($sformatf("ram%0d_wdata", idx), 32'(wd), 32'(r.wdata));
      end
    end else begin
      chk($sformatf("ram%0d_idle_zero", idx), 32'({rw, a, wd}), 32'd0);
    end
    if (fv) begin
      n = (idx == 0) ? exp_fill0.size() : exp_fill1.size();
      if (n == 0) begin
        checks++; errors++;
        $display("FAIL fill%0d_unexpected at cycle %0d: actual addr=%0h data=%0h required no fill",
                 idx, cyc, fa, fd);
      end else begin
        if (idx == 0) f = exp_fill0.pop_front();
        else          f = exp_fill1.pop_front();
        chk($sformatf("fill%0d_cycle", idx), cyc, f.cyc);
        chk($sformatf("fill%0d_way", idx), 32'(w), 32'(f.way));
        chk($sformatf("fill%0d_addr", idx), 32'(fa), 32'(f.addr));
        chk($sformatf("fill%0d_data", idx), 32'(fd), 32'(f.data));
        chk($sformatf("fill%0d_dirty", idx), 32'(fdirty), 32'(f.dirty));
      end
    end
  endtask

  always @(negedge clk) if (mon_en)
    mon(0, ram_enab0, ram_rw0, ram_addr0, ram_wdata0, fill_valid0, fill_way0, fill_addr0,
        fill_data0, fill_dirty0);
  always @(negedge clk) if (mon_en)
    mon(1, ram_enab1, ram_rw1, ram_addr1, ram_wdata1, fill_valid1, fill_way1, fill_addr1,
        fill_data1, fill_dirty1);

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one miss for one cycle to u0 (tgt 0) or u1 (tgt 1).
  task automatic issue(input int tgt, input logic rw, input logic [7:0] a, input logic [7:0] wd,
                       input logic [1:0] w, input logic vv, input logic vd,
                       input logic [7:0] va, input logic [7:0] vdat);
    miss_rw = rw; miss_addr = a; miss_wdata = wd; miss_way = w;
    victim_valid = vv; victim_dirty = vd; victim_addr = va; victim_data = vdat;
    if (tgt == 0) miss_req0 = 1'b1;
    else          miss_req1 = 1'b1;
    wait_cyc(1);
    miss_req0 = 1'b0;
    miss_req1 = 1'b0;
  endtask

  int c0;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 + i);
    mem[5] = 8'hA7;
    mem[6] = 8'hC3;
    clr = 1'b1; miss_req0 = 1'b0; miss_req1 = 1'b0; miss_rw = 1'b0;
    miss_addr = '0; miss_wdata = '0; miss_way = '0;
    victim_valid = 1'b0; victim_dirty = 1'b0; victim_addr = '0; victim_data = '0;
    wait_cyc(3);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_overrun", 32'(overrun0), 0);
    chk("rst_fill_valid", 32'(fill_valid0), 0);
    chk("rst_ram_enab", 32'(ram_enab0), 0);
    chk("rst_fill_data", 32'({fill_way0, fill_addr0, fill_data0, fill_dirty0}), 0);
    clr = 1'b0;
    mon_en = 1'b1;
    wait_cyc(1);

    // Clean read miss
    c0 = cyc;
    push_ram(0, c0 + 1, 1'b0, 3'd5, 8'h00);
    push_ram(0, c0 + 2, 1'b0, 3'd5, 8'h00);
    push_fill(0, c0 + 3, 2'd2, 8'h05, 8'hA7, 1'b0);
    issue(0, 1'b0, 8'h05, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("clean_rd_busy", 32'(busy0), 1);
    wait_cyc(4);
    chk("clean_rd_idle", 32'(busy0), 0);

    // Dirty read miss
    c0 = cyc;
    push_ram(0, c0 + 1, 1'b1, 3'd2, 8'h3C);
    push_ram(0, c0 + 2, 1'b1, 3'd2, 8'h3C);
    push_ram(0, c0 + 3, 1'b0, 3'd6, 8'h00);
    push_ram(0, c0 + 4, 1'b0, 3'd6, 8'h00);
    push_fill(0, c0 + 5, 2'd1, 8'h06, 8'hC3, 1'b0);
    issue(0, 1'b0, 8'h06, 8'h00, 2'd1, 1'b1, 1'b1, 8'h02, 8'h3C);
    wait_cyc(6);

    // Clean write miss (valid but clean victim: no writeback)
    c0 = cyc;
    push_fill(0, c0 + 1, 2'd3, 8'h01, 8'h55, 1'b1);
    issue(0, 1'b1, 8'h01, 8'h55, 2'd3, 1'b1, 1'b0, 8'h07, 8'hEE);
    chk("clean_wr_busy", 32'(busy0), 1);
    wait_cyc(1);
    chk("clean_wr_idle", 32'(busy0), 0);
    wait_cyc(1);

    // Dirty write miss; upper address bits dropped for RAM, kept in fill_addr
    c0 = cyc;
    push_ram(0, c0 + 1, 1'b1, 3'd3, 8'h99);
    push_ram(0, c0 + 2, 1'b1, 3'd3, 8'h99);
    push_fill(0, c0 + 3, 2'd0, 8'hF4, 8'h66, 1'b1);
    issue(0, 1'b1, 8'hF4, 8'h66, 2'd0, 1'b1, 1'b1, 8'h0B, 8'h99);
    wait_cyc(4);
    chk("overrun_before", 32'(overrun0), 0);

    // Overrun: second request during the read phase is ignored
    c0 = cyc;
    push_ram(0, c0 + 1, 1'b0, 3'd6, 8'h00);
    push_ram(0, c0 + 2, 1'b0, 3'd6, 8'h00);
    push_fill(0, c0 + 3, 2'd2, 8'h8E, 8'hC3, 1'b0);
    issue(0, 1'b0, 8'h8E, 8'h00, 2'd2, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_cyc(1);
    issue(0, 1'b1, 8'h01, 8'hFF, 2'd1, 1'b1, 1'b1, 8'h04, 8'h77);
    chk("overrun_set", 32'(overrun0), 1);
    wait_cyc(3);
    chk("overrun_sticky", 32'(overrun0), 1);
    chk("overrun_idle", 32'(busy0), 0);

    // Reset during the read phase of a dirty read miss
    c0 = cyc;
    push_ram(0, c0 + 1, 1'b1, 3'd2, 8'h3C);
    push_ram(0, c0 + 2, 1'b1, 3'd2, 8'h3C);
    push_ram(0, c0 + 3, 1'b0, 3'd6, 8'h00);
    issue(0, 1'b0, 8'h06, 8'h00, 2'd1, 1'b1, 1'b1, 8'h02, 8'h3C);
    wait_cyc(2);
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    chk("clr_busy", 32'(busy0), 0);
    chk("clr_ram_enab", 32'(ram_enab0), 0);
    chk("clr_fill_valid", 32'(fill_valid0), 0);
    chk("clr_overrun", 32'(overrun0), 0);
    wait_cyc(6);

    // Back-to-back clean read misses with RAM_LAT=1
    c0 = cyc;
    push_ram(1, c0 + 1, 1'b0, 3'd5, 8'h00);
    push_fill(1, c0 + 2, 2'd1, 8'h05, 8'hA7, 1'b0);
    push_ram(1, c0 + 4, 1'b0, 3'd6, 8'h00);
    push_fill(1, c0 + 5, 2'd3, 8'h16, 8'hC3, 1'b0);
    issue(1, 1'b0, 8'h05, 8'h00, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_cyc(2);
    issue(1, 1'b0, 8'h16, 8'h00, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_cyc(3);
    chk("b2b_overrun", 32'(overrun1), 0);
    chk("b2b_idle", 32'(busy1), 0);
`ifdef MISS_STATS_EN
    chk("b2b_miss_cnt", 32'(miss_cnt1), 2);
    chk("b2b_wb_cnt", 32'(wb_cnt1), 0);
`endif

    wait_cyc(2);
    chk("left_ram0", exp_ram0.size(), 0);
    chk("left_fill0", exp_fill0.size(), 0);
    chk("left_ram1", exp_ram1.size(), 0);
    chk("left_fill1", exp_fill1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
